// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-word layout, ALU opcodes and the bubble control value.
package pipeline_pkg;

  // Control word, MSB first: {alu_op[3:0], alu_src, mem_rd, mem_wr, reg_wr, reg_dst}
  localparam int unsigned CTRL_W      = 9;
  localparam int unsigned ALU_OP_MSB  = 8;
  localparam int unsigned ALU_OP_LSB  = 5;
  localparam int unsigned ALU_SRC_BIT = 4;
  localparam int unsigned MEM_RD_BIT  = 3;
  localparam int unsigned MEM_WR_BIT  = 2;
  localparam int unsigned REG_WR_BIT  = 1;
  localparam int unsigned REG_DST_BIT = 0;

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluSub = 4'd1,
    AluAnd = 4'd2,
    AluOr  = 4'd3,
    AluXor = 4'd4,
    AluNor = 4'd5,
    AluSlt = 4'd6,
    AluSll = 4'd7,
    AluSrl = 4'd8,
    AluSra = 4'd9,
    AluLui = 4'd10
  } alu_op_e;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load sitting in EX and the sources of the ID instruction.
module hazard_detect #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              id_valid,
  input  logic              ex_valid,
  input  logic              ex_mem_rd,
  input  logic [ADDR_W-1:0] ex_dest,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic              id_uses_rt,
  input  logic              ex_flush,
  output logic              hz_stall
);

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = (ex_dest == id_rs_addr);
    rt_match = id_uses_rt && (ex_dest == id_rt_addr);
    // Flush masks the stall so a wrong-path instruction never freezes the front end.
    hz_stall = id_valid && ex_valid && ex_mem_rd && (ex_dest != '0) &&
               (rs_match || rt_match) && !ex_flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with WB bypass, $0 forcing, load-use stall and branch flush.
module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs_addr,
  input  logic [ADDR_W-1:0] id_rt_addr,
  input  logic [ADDR_W-1:0] id_rd_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_uses_rt,
  input  logic              wb_wr,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_flush,
  output logic              hz_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [ADDR_W-1:0] ex_rs_addr,
  output logic [ADDR_W-1:0] ex_rt_addr,
  output logic [ADDR_W-1:0] ex_dest,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              valid_q,   valid_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q,     imm_d;
  logic [CTRL_W-1:0] ctrl_q,    ctrl_d;
  logic [ADDR_W-1:0] rs_addr_q, rs_addr_d;
  logic [ADDR_W-1:0] rt_addr_q, rt_addr_d;
  logic [ADDR_W-1:0] dest_q,    dest_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;

  logic [CTRL_W-1:0] ctrl_in;
  logic [ADDR_W-1:0] dest_in;
  logic [DATA_W-1:0] rs_byp;
  logic [DATA_W-1:0] rt_byp;

  hazard_detect #(
    .ADDR_W (ADDR_W)
  ) u_hazard_detect (
    .id_valid   (id_valid),
    .ex_valid   (valid_q),
    .ex_mem_rd  (ctrl_q[MEM_RD_BIT]),
    .ex_dest    (dest_q),
    .id_rs_addr (id_rs_addr),
    .id_rt_addr (id_rt_addr),
    .id_uses_rt (id_uses_rt),
    .ex_flush   (ex_flush),
    .hz_stall   (hz_stall)
  );

  always_comb begin
    ctrl_in = id_valid ? id_ctrl : CTRL_NOP;
    dest_in = ctrl_in[REG_WR_BIT] ? (ctrl_in[REG_DST_BIT] ? id_rd_addr : id_rt_addr) : '0;

    // The regfile write lands on this edge, so its read ports still show the old value.
    // A nonzero source address matching wb_addr also implies wb_addr != 0.
    if (id_rs_addr == '0)                     rs_byp = '0;
    else if (wb_wr && wb_addr == id_rs_addr)  rs_byp = wb_data;
    else                                      rs_byp = id_rs_data;

    if (id_rt_addr == '0)                     rt_byp = '0;
    else if (wb_wr && wb_addr == id_rt_addr)  rt_byp = wb_data;
    else                                      rt_byp = id_rt_data;

    if (ex_flush || hz_stall) begin
      valid_d   = 1'b0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
      ctrl_d    = CTRL_NOP;
      rs_addr_d = '0;
      rt_addr_d = '0;
      dest_d    = '0;
    end else begin
      valid_d   = id_valid;
      rs_data_d = rs_byp;
      rt_data_d = rt_byp;
      imm_d     = id_imm;
      ctrl_d    = ctrl_in;
      rs_addr_d = id_rs_addr;
      rt_addr_d = id_rt_addr;
      dest_d    = dest_in;
    end

    cnt_d = cnt_q;
    if (hz_stall && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= CTRL_NOP;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      dest_q    <= '0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      dest_q    <= dest_d;
      cnt_q     <= cnt_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_rs_data = rs_data_q;
  assign ex_rt_data = rt_data_q;
  assign ex_imm     = imm_q;
  assign ex_ctrl    = ctrl_q;
  assign ex_rs_addr = rs_addr_q;
  assign ex_rt_addr = rt_addr_q;
  assign ex_dest    = dest_q;
  assign stall_cnt  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expectations, a negedge monitor checks.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs_addr = '0, id_rt_addr = '0, id_rd_addr = '0;
  logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
  logic [8:0]  id_ctrl = '0;
  logic        id_uses_rt = 1'b0;
  logic        wb_wr = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        ex_flush = 1'b0;

  logic        hz_stall, ex_valid;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [8:0]  ex_ctrl;
  logic [4:0]  ex_rs_addr, ex_rt_addr, ex_dest;
  logic [15:0] stall_cnt;

  // Narrow-counter copy driven by the same stimulus, used for the saturation check.
  logic        s_hz_stall, s_ex_valid;
  logic [31:0] s_ex_rs_data, s_ex_rt_data, s_ex_imm;
  logic [8:0]  s_ex_ctrl;
  logic [4:0]  s_ex_rs_addr, s_ex_rt_addr, s_ex_dest;
  logic [5:0]  s_stall_cnt;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_uses_rt(id_uses_rt),
    .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data), .ex_flush(ex_flush),
    .hz_stall(hz_stall), .ex_valid(ex_valid), .ex_rs_data(ex_rs_data),
    .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_rs_addr(ex_rs_addr),
    .ex_rt_addr(ex_rt_addr), .ex_dest(ex_dest), .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.CNT_W(6)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr), .id_rs_data(id_rs_data),
    .id_rt_data(id_rt_data), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_uses_rt(id_uses_rt),
    .wb_wr(wb_wr), .wb_addr(wb_addr), .wb_data(wb_data), .ex_flush(ex_flush),
    .hz_stall(s_hz_stall), .ex_valid(s_ex_valid), .ex_rs_data(s_ex_rs_data),
    .ex_rt_data(s_ex_rt_data), .ex_imm(s_ex_imm), .ex_ctrl(s_ex_ctrl),
    .ex_rs_addr(s_ex_rs_addr), .ex_rt_addr(s_ex_rt_addr), .ex_dest(s_ex_dest),
    .stall_cnt(s_stall_cnt)
  );

  localparam logic [8:0] C_ADD = 9'h003;  // alu add, reg_wr, reg_dst
  localparam logic [8:0] C_SUB = 9'h023;  // alu sub, reg_wr, reg_dst
  localparam logic [8:0] C_LW  = 9'h01A;  // alu add, alu_src, mem_rd, reg_wr

  typedef struct {
    logic rst, vld; logic [4:0] rs, rt, rd; logic [31:0] rsd, rtd, imm; logic [8:0] ctrl;
    logic urt, wbw; logic [4:0] wba; logic [31:0] wbd; logic fl;
  } in_t;

  typedef struct {
    int id; bit chk; logic hz, vld; logic [4:0] rsa, rta, dest; logic [31:0] rsd, rtd, imm;
    logic [8:0] ctrl; logic [15:0] cnt; logic [5:0] cnt6;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   vec_id = 0;

  function automatic in_t mk(logic r, logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                             logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm,
                             logic [8:0] c, logic urt, logic wbw, logic [4:0] wba,
                             logic [31:0] wbd, logic fl);
    in_t t;
    t.rst = r; t.vld = v; t.rs = rs; t.rt = rt; t.rd = rd; t.rsd = rsd; t.rtd = rtd;
    t.imm = imm; t.ctrl = c; t.urt = urt; t.wbw = wbw; t.wba = wba; t.wbd = wbd; t.fl = fl;
    return t;
  endfunction

  function automatic exp_t ex(bit chk, logic hz, logic v, logic [4:0] rsa, logic [4:0] rta,
                              logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm,
                              logic [8:0] c, logic [4:0] dest, int cnt);
    exp_t e;
    e.id = 0; e.chk = chk; e.hz = hz; e.vld = v; e.rsa = rsa; e.rta = rta; e.rsd = rsd;
    e.rtd = rtd; e.imm = imm; e.ctrl = c; e.dest = dest; e.cnt = 16'(cnt);
    e.cnt6 = (cnt > 63) ? 6'd63 : 6'(cnt);
    return e;
  endfunction

  task automatic vec(input in_t t, input exp_t e);
    @(posedge clk);
    #1;
    rst = t.rst; id_valid = t.vld; id_rs_addr = t.rs; id_rt_addr = t.rt; id_rd_addr = t.rd;
    id_rs_data = t.rsd; id_rt_data = t.rtd; id_imm = t.imm; id_ctrl = t.ctrl;
    id_uses_rt = t.urt; wb_wr = t.wbw; wb_addr = t.wba; wb_data = t.wbd; ex_flush = t.fl;
    vec_id++;
    e.id = vec_id;
    exp_q.push_back(e);
  endtask

  // Monitor: each cycle's outputs are checked at the negedge against the queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      bit   ok;
      e  = exp_q.pop_front();
      ok = (hz_stall === e.hz) && (ex_valid === e.vld) && (stall_cnt === e.cnt) &&
           (s_stall_cnt === e.cnt6);
      if (e.chk)
        ok = ok && (ex_rs_addr === e.rsa) && (ex_rt_addr === e.rta) && (ex_dest === e.dest) &&
             (ex_rs_data === e.rsd) && (ex_rt_data === e.rtd) && (ex_imm === e.imm) &&
             (ex_ctrl === e.ctrl);
      n_checks++;
      if (ok) n_pass++;
      else
        $display("FAIL vec%0d: got hz=%b v=%b rsa=%0d rta=%0d dest=%0d rs=%h rt=%h imm=%h ctrl=%h cnt=%h cnt6=%h | want hz=%b v=%b rsa=%0d rta=%0d dest=%0d rs=%h rt=%h imm=%h ctrl=%h cnt=%h cnt6=%h (data %0s)",
                 e.id, hz_stall, ex_valid, ex_rs_addr, ex_rt_addr, ex_dest, ex_rs_data,
                 ex_rt_data, ex_imm, ex_ctrl, stall_cnt, s_stall_cnt, e.hz, e.vld, e.rsa,
                 e.rta, e.dest, e.rsd, e.rtd, e.imm, e.ctrl, e.cnt, e.cnt6,
                 e.chk ? "checked" : "ignored");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    in_t lw44;
    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      vec(mk(1, 1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom,
             $urandom, 9'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), $urandom,
             1'($urandom)),
          ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // add $3,$1,$2
    vec(mk(0, 1, 1, 2, 3, 24, 16, 0, C_ADD, 1, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // WB bypass on rs
    vec(mk(0, 1, 1, 2, 6, 24, 16, 0, C_ADD, 1, 1, 1, 32'h55, 0),
        ex(1, 0, 1, 1, 2, 24, 16, 0, C_ADD, 3, 0));
    // $0 source with a WB write to $0
    vec(mk(0, 1, 0, 2, 7, 24, 16, 0, C_ADD, 1, 1, 0, 32'h55, 0),
        ex(1, 0, 1, 1, 2, 32'h55, 16, 0, C_ADD, 6, 0));
    // lw $4, 8($1)
    vec(mk(0, 1, 1, 4, 0, 100, 77, 8, C_LW, 0, 0, 0, 0, 0),
        ex(1, 0, 1, 0, 2, 0, 16, 0, C_ADD, 7, 0));
    // sub $5,$4,$1 -> stall for one cycle, then bubble, then captured
    vec(mk(0, 1, 4, 1, 5, 9, 100, 0, C_SUB, 1, 0, 0, 0, 0),
        ex(1, 1, 1, 1, 4, 100, 77, 8, C_LW, 4, 0));
    vec(mk(0, 1, 4, 1, 5, 9, 100, 0, C_SUB, 1, 0, 0, 0, 0),
        ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    // add $8,$2,$5 with WB bypass on rt
    vec(mk(0, 1, 2, 5, 8, 3, 4, 0, C_ADD, 1, 1, 5, 32'hAA, 0),
        ex(1, 0, 1, 4, 1, 9, 100, 0, C_SUB, 5, 1));
    // lw $9, 4($2)
    vec(mk(0, 1, 2, 9, 0, 3, 0, 4, C_LW, 0, 0, 0, 0, 0),
        ex(1, 0, 1, 2, 5, 3, 32'hAA, 0, C_ADD, 8, 1));
    // load-use on $9 together with flush: no stall, bubble, count unchanged
    vec(mk(0, 1, 9, 0, 10, 1, 2, 0, C_ADD, 1, 0, 0, 0, 1),
        ex(1, 0, 1, 2, 9, 3, 0, 4, C_LW, 9, 1));
    // invalid ID: control forced to zero, data still captured
    vec(mk(0, 0, 3, 4, 0, 32'h11, 32'h22, 32'h33, C_ADD, 0, 0, 0, 0, 0),
        ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
        ex(1, 0, 0, 3, 4, 32'h11, 32'h22, 32'h33, 0, 0, 1));
    // reset asserted during a stall
    vec(mk(0, 1, 1, 4, 0, 5, 0, 0, C_LW, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vec(mk(1, 1, 4, 1, 5, 9, 100, 0, C_SUB, 1, 0, 0, 0, 0),
        ex(1, 1, 1, 1, 4, 5, 0, 0, C_LW, 4, 1));
    vec(mk(0, 1, 4, 1, 5, 9, 100, 0, C_SUB, 1, 0, 0, 0, 0),
        ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
        ex(1, 0, 1, 4, 1, 9, 100, 0, C_SUB, 5, 0));
    // lw $4,0($4) held in ID: stalls every other cycle; narrow counter saturates at 63
    lw44 = mk(0, 1, 4, 4, 0, 0, 0, 0, C_LW, 0, 0, 0, 0, 0);
    for (int i = 0; i < 67; i++) begin
      vec(lw44, ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, i));
      vec(lw44, ex(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, i));
    end
    vec(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 67));
    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly downstream of the register file in the 5-stage MIPS pipeline.
- Captures the two register-file read ports, the immediate and the decoded control into the EX-side register set.
- Corrects same-cycle writeback conflicts, forces $0 reads to zero, and detects load-use hazards.
- On a load-use hazard it stalls IF/ID and inserts a bubble into EX. Branch flush is also handled here.

Parameters:
- DATA_W, 32, datapath width.
- ADDR_W, 5, register address width.
- CNT_W, 16, stall performance counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs_addr  in  ADDR_W  rs address; also drives register file Addr_A.
- id_rt_addr  in  ADDR_W  rt address; also drives register file Addr_B.
- id_rd_addr  in  ADDR_W  rd field.
- id_rs_data  in  DATA_W  register file Port_A.
- id_rt_data  in  DATA_W  register file Port_B.
- id_imm  in  DATA_W  sign/zero-extended immediate.
- id_ctrl  in  CTRL_W  packed decode: alu_op[3:0], alu_src, mem_rd, mem_wr, reg_wr, reg_dst.
- id_uses_rt  in  1  instruction reads rt as a source.
- wb_wr  in  1  writeback enable; the same signal as the register file wr.
- wb_addr  in  ADDR_W  writeback address (register file Addr_Wr).
- wb_data  in  DATA_W  writeback data (register file Din).
- ex_flush  in  1  branch taken or jump resolved in EX; kill the ID instruction.
- hz_stall  out  1  combinational; holds PC and IF/ID.
- ex_valid  out  1  EX-side valid.
- ex_rs_data  out  DATA_W  registered rs value.
- ex_rt_data  out  DATA_W  registered rt value.
- ex_imm  out  DATA_W  registered immediate.
- ex_ctrl  out  CTRL_W  registered control.
- ex_rs_addr  out  ADDR_W  source tag, for the downstream forwarding unit.
- ex_rt_addr  out  ADDR_W  source tag, for the downstream forwarding unit.
- ex_dest  out  ADDR_W  resolved destination register.
- stall_cnt  out  CNT_W  cycles with hz_stall asserted.

Behaviour:
- Single clock domain: clk. Reset is synchronous and active-high (rst).
- Reset value of every registered output is 0, including stall_cnt. hz_stall follows its inputs, and is 0 when ex_valid=0.
- Latency: one cycle from ID inputs to ex_* outputs.
- WB bypass: the register file writes on the clk edge and reads combinationally, so a same-cycle write is not yet visible on its read ports.
  - If wb_wr && wb_addr!=0 && wb_addr==id_rs_addr, the captured rs value is wb_data; otherwise it is id_rs_data.
  - rt is handled the same way.
- $0 rule: a source address of 0 captures 0, regardless of the read data or a WB write to address 0.
- Destination resolution: ex_dest <= reg_wr ? (reg_dst ? id_rd_addr : id_rt_addr) : 0.
- Load-use hazard, combinational:
  - hz_stall = id_valid && ex_valid && ex_ctrl.mem_rd && ex_dest!=0 && (ex_dest==id_rs_addr || (id_uses_rt && ex_dest==id_rt_addr)) && !ex_flush.
- Next-state priority, highest first:
  - rst: all registers cleared.
  - ex_flush: bubble (ex_valid=0, ex_ctrl=0, ex_dest=0; data fields don't-care but cleared).
  - hz_stall: bubble, same as flush. The ID instruction is held upstream and re-presented next cycle.
  - Otherwise: capture, with ex_valid <= id_valid. If id_valid=0, ex_ctrl is forced to 0.
- Stall always resolves after exactly one bubble: the bubble has mem_rd=0, so no back-to-back stall arises from the same load.
- stall_cnt: increments each cycle hz_stall=1 and saturates at all-ones (no wrap). It is cleared only by rst.
- Flush and stall in the same cycle: flush wins and hz_stall is masked to 0, so a wrong-path instruction never freezes the front end.
- Reset asserted mid-stall: the next cycle has ex_valid=0, hz_stall=0, stall_cnt=0.

Decomposition:
- Shared package (pipeline_pkg) holds:
  - CTRL_W, and the bit indices of alu_op/alu_src/mem_rd/mem_wr/reg_wr/reg_dst;
  - the ALU opcode constants;
  - the NOP/bubble control value (all zero).
- One natural sub-module: hazard_detect, which holds the combinational load-use compare. The bypass muxes and the pipeline register stay in id_ex_stage.

Test Plan:
- rst=1 for 2 cycles with random inputs -> all ex_* outputs, stall_cnt and hz_stall are 0.
- ID add $3,$1,$2 with Port_A=24, Port_B=16, reg_dst=1, rd=3 -> next cycle ex_rs_data=24, ex_rt_data=16, ex_dest=3, ex_valid=1.
- wb_wr=1, wb_addr=1, wb_data=0x55 while id_rs_addr=1 and Port_A=24 -> ex_rs_data=0x55. The same stimulus with wb_addr=0 and id_rs_addr=0 -> ex_rs_data=0.
- lw $4 in EX, then ID sub $5,$4,$1 -> hz_stall=1 for exactly one cycle, then ex_valid=0/ex_ctrl=0 (bubble); the held sub is captured next cycle; stall_cnt=1.
- Load-use condition together with ex_flush=1 -> hz_stall=0, bubble inserted, stall_cnt unchanged.
- Force 2^CNT_W+3 stall cycles -> stall_cnt holds 0xFFFF and does not wrap.
